// File: rtl/amp_seq_ctrl.sv
// Power-up / fault-recovery sequencer for a multi-channel amplifier: enable settle,
// config send, run with per-channel lock muting, counted fault back-off and lockout.
module amp_seq_ctrl #(
    parameter int N_CH      = 2,
    parameter int TW        = 16,
    parameter int T_ENABLE  = 1000,
    parameter int T_CFG     = 1000,
    parameter int T_RETRY   = 5000,
    parameter int T_STABLE  = 10000,
    parameter int MAX_RETRY = 3
) (
    input  logic            clk_in,
    input  logic            resetb,
    input  logic [N_CH-1:0] audio_locked_in,
    input  logic [N_CH-1:0] nerror_in,
    input  logic            clear_fault_in,
    output logic            nenable_out,
    output logic [N_CH-1:0] nmute_out,
    output logic            send_config_out,
    output logic            fault_out,
    output logic [2:0]      state_out,
    output logic [2:0]      retry_cnt_out
);

    localparam logic [2:0] S_INIT        = 3'd0;
    localparam logic [2:0] S_ENABLE_WAIT = 3'd1;
    localparam logic [2:0] S_SEND_CFG    = 3'd2;
    localparam logic [2:0] S_RUN         = 3'd3;
    localparam logic [2:0] S_FAULT       = 3'd4;
    localparam logic [2:0] S_LOCKOUT     = 3'd5;

    localparam logic [TW-1:0] LD_ENABLE = TW'(T_ENABLE - 1);
    localparam logic [TW-1:0] LD_CFG    = TW'(T_CFG - 1);
    localparam logic [TW-1:0] LD_RETRY  = TW'(T_RETRY - 1);
    localparam logic [TW-1:0] LD_STABLE = TW'(T_STABLE - 1);
    localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

    logic [2:0]      r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_retry;
    logic            r_nenable;
    logic [N_CH-1:0] r_nmute;
    logic            r_send;
    logic            r_fault;

    logic [2:0]      w_next_state;
    logic [TW-1:0]   w_timer_next;
    logic [2:0]      w_retry_next;
    logic            w_timer_zero;
    logic            w_any_err;

    assign w_timer_zero = (r_timer == '0);
    assign w_any_err    = ~&nerror_in;

    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:        w_next_state = S_ENABLE_WAIT;
            S_ENABLE_WAIT: if (w_timer_zero) w_next_state = S_SEND_CFG;
            S_SEND_CFG: begin
                if (w_any_err)         w_next_state = S_FAULT;
                else if (w_timer_zero) w_next_state = S_RUN;
            end
            S_RUN:         if (w_any_err) w_next_state = S_FAULT;
            S_FAULT: begin
                if (w_timer_zero)
                    w_next_state = (r_retry < RETRY_MAX) ? S_ENABLE_WAIT : S_LOCKOUT;
            end
            S_LOCKOUT:     if (clear_fault_in) w_next_state = S_INIT;
            default:       w_next_state = S_INIT;
        endcase
    end

    // The timer reloads only on a state change; RUN therefore saturates at 0 after T_STABLE.
    always_comb begin
        w_timer_next = r_timer;
        if (w_next_state != r_state) begin
            case (w_next_state)
                S_ENABLE_WAIT: w_timer_next = LD_ENABLE;
                S_SEND_CFG:    w_timer_next = LD_CFG;
                S_RUN:         w_timer_next = LD_STABLE;
                S_FAULT:       w_timer_next = LD_RETRY;
                default:       w_timer_next = '0;
            endcase
        end else if (!w_timer_zero) begin
            w_timer_next = r_timer - 1'b1;
        end
    end

    always_comb begin
        w_retry_next = r_retry;
        if (w_next_state == S_FAULT && r_state != S_FAULT)
            w_retry_next = (r_retry == 3'd7) ? 3'd7 : r_retry + 3'd1;
        else if (r_state == S_LOCKOUT && w_next_state == S_INIT)
            w_retry_next = '0;
        else if (r_state == S_RUN && w_next_state == S_RUN && w_timer_zero)
            w_retry_next = '0;
    end

    // NOTE: outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_state   <= S_INIT;
            r_timer   <= '0;
            r_retry   <= '0;
            r_nenable <= 1'b1;
            r_nmute   <= '0;
            r_send    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_timer   <= w_timer_next;
            r_retry   <= w_retry_next;
            r_nenable <= !(w_next_state == S_ENABLE_WAIT || w_next_state == S_SEND_CFG ||
                           w_next_state == S_RUN);
            r_send    <= (w_next_state == S_SEND_CFG || w_next_state == S_RUN);
            r_nmute   <= (w_next_state == S_RUN) ? (audio_locked_in & nerror_in) : '0;
            r_fault   <= (w_next_state == S_LOCKOUT);
        end
    end

    assign nenable_out     = r_nenable;
    assign nmute_out       = r_nmute;
    assign send_config_out = r_send;
    assign fault_out       = r_fault;
    assign state_out       = r_state;
    assign retry_cnt_out   = r_retry;

endmodule

// File: doc/amp_seq_ctrl.md
AMP_SEQ_CTRL -- requirements
Module: amp_seq_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of amplifier channels (1..8).
REQ-002 SHALL have parameter TW, default 16, timer width in bits.
REQ-003 SHALL have parameter T_ENABLE, default 1000, enable-settle time in cycles (1..2^TW-1).
REQ-004 SHALL have parameter T_CFG, default 1000, config-send time in cycles (1..2^TW-1).
REQ-005 SHALL have parameter T_RETRY, default 5000, fault back-off time in cycles (1..2^TW-1).
REQ-006 SHALL have parameter T_STABLE, default 10000, fault-free RUN time that clears the retry count (1..2^TW-1).
REQ-007 SHALL have parameter MAX_RETRY, default 3, fault count that causes lockout (1..7).
REQ-008 clk_in  input  1  single clock; all flops rise-edge.
REQ-009 resetb  input  1  asynchronous, active-low reset.
REQ-010 audio_locked_in  input  N_CH  per-channel audio lock; 1 = locked.
REQ-011 nerror_in  input  N_CH  per-channel amplifier error; 0 = error.
REQ-012 clear_fault_in  input  1  level request that leaves LOCKOUT.
REQ-013 nenable_out  output  1  amplifier enable; 0 = enabled.
REQ-014 nmute_out  output  N_CH  per-channel mute; 0 = muted.
REQ-015 send_config_out  output  1  config transmitter enable.
REQ-016 fault_out  output  1  1 while in LOCKOUT.
REQ-017 state_out  output  3  current state encoding.
REQ-018 retry_cnt_out  output  3  faults counted since the last clear.

Function
REQ-019 SHALL implement states INIT=0, ENABLE_WAIT=1, SEND_CFG=2, RUN=3, FAULT=4, LOCKOUT=5; codes 6-7 SHALL go to INIT on the next edge.
REQ-020 All outputs SHALL be registered and SHALL change on the same edge as the state they reflect.
REQ-021 A single down-counter timer SHALL be loaded with T_x-1 on entry to a timed state, decrement each cycle, and signal expiry at 0, so each timed state lasts exactly T_x cycles.
REQ-022 INIT SHALL last one cycle (nenable=1, send_config=0, all nmute=0) and then go to ENABLE_WAIT.
REQ-023 ENABLE_WAIT SHALL drive nenable=0 and send_config=0; nerror_in is ignored; at expiry go to SEND_CFG.
REQ-024 SEND_CFG SHALL drive nenable=0 and send_config=1; at expiry go to RUN; any nerror_in bit sampled 0 SHALL go to FAULT instead (fault has priority over expiry).
REQ-025 RUN SHALL drive nenable=0 and send_config=1; nmute_out[i] SHALL be the registered value of audio_locked_in[i] AND nerror_in[i], sampled on the edge entering or remaining in RUN.
REQ-026 In RUN, any nerror_in bit sampled 0 SHALL go to FAULT; channels SHALL NOT be faulted independently.
REQ-027 In RUN, the timer SHALL count T_STABLE; at expiry retry_cnt SHALL be cleared to 0 and the timer SHALL not reload (saturate at 0).
REQ-028 On entry to FAULT, retry_cnt SHALL increment by 1 (saturating at 7), and nenable=1, send_config=0, all nmute=0.
REQ-029 At FAULT expiry, SHALL go to ENABLE_WAIT if retry_cnt < MAX_RETRY, else to LOCKOUT.
REQ-030 LOCKOUT SHALL drive nenable=1, send_config=0, all nmute=0, fault_out=1; clear_fault_in sampled 1 SHALL go to INIT with retry_cnt=0.
REQ-031 clear_fault_in SHALL be ignored in every state except LOCKOUT.
REQ-032 Lock loss SHALL only mute the affected channel and SHALL NOT change state.

Reset
REQ-033 resetb=0 SHALL immediately force state=INIT, timer=0, retry_cnt=0, nenable_out=1, nmute_out=0, send_config_out=0, fault_out=0, regardless of clk_in.
REQ-034 Reset asserted mid-sequence (including LOCKOUT) SHALL discard all progress; the first edge after release SHALL enter ENABLE_WAIT from INIT.

Verification (N_CH=2, T_ENABLE=4, T_CFG=3, T_RETRY=5, T_STABLE=8, MAX_RETRY=2)
REQ-035 Startup, all locked and no errors -> nenable falls at edge 1, send_config rises at edge 5, nmute_out=2'b11 at edge 8, state_out=3.
REQ-036 In RUN, audio_locked_in=2'b01 for 3 cycles -> nmute_out=2'b01 one edge later, state stays 3, restored to 2'b11 one edge after relock.
REQ-037 nerror_in[1]=0 for one cycle in RUN -> FAULT at that edge (nenable=1, nmute=00, retry_cnt=1), ENABLE_WAIT 5 cycles later, RUN again after 7 more cycles.
REQ-038 Error in RUN twice within T_STABLE -> second FAULT expiry enters LOCKOUT, fault_out=1; clear_fault_in=1 -> INIT, retry_cnt=0, normal restart.
REQ-039 One fault, then 8 fault-free RUN cycles -> retry_cnt_out=0; a later fault yields retry_cnt=1, not LOCKOUT.
REQ-040 resetb pulsed low between edges during SEND_CFG -> outputs take reset values immediately, without a clock edge; startup timing identical to REQ-035 after release.
